// File: rtl/iir_biquad_sched_if.sv
// Sample-in / result-out handshake bundle for iir_biquad_sched.
// master = sample source and result sink, slave = the biquad.
interface iir_biquad_sched_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_data;
  logic signed [26:0] out_acc;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_acc
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_acc
  );
endinterface

// File: rtl/iir_biquad_sched.sv
// DF-I biquad with one shared 12x12 multiplier, one tap per cycle.
// Define IIR_SAT_EN to saturate the output; otherwise it wraps.
module iir_biquad_sched (
  input  logic               clk,
  input  logic               rst_n,
  iir_biquad_sched_if.slave  bus,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic signed [11:0] cfg_data,
  output logic               cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2,
    S_MAC3, S_MAC4, S_OUT
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [11:0] r_b0, r_b1, r_b2;
  logic signed [11:0] r_a1, r_a2;
  logic signed [11:0] r_x0, r_x1, r_x2;
  logic signed [11:0] r_y1, r_y2;
  logic signed [26:0] r_acc;
  logic signed [26:0] r_out_acc;
  logic signed [11:0] r_out_data;
  logic               r_cfg_err;

  logic signed [11:0] w_coef, w_samp;
  logic               w_neg;
  logic signed [23:0] w_prod;
  logic signed [26:0] w_prod_ext;
  logic signed [26:0] w_acc_nxt;
  logic signed [11:0] w_scaled;
  logic               w_cfg_ok;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_out_data;
  assign bus.out_acc   = r_out_acc;
  assign cfg_err       = r_cfg_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: fixed tap walk, waits only in IDLE and OUT
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_MAC0;
      S_MAC0:  w_state_nxt = S_MAC1;
      S_MAC1:  w_state_nxt = S_MAC2;
      S_MAC2:  w_state_nxt = S_MAC3;
      S_MAC3:  w_state_nxt = S_MAC4;
      S_MAC4:  w_state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the tap feeding the shared multiplier
  always_comb begin
    w_coef = r_b0;
    w_samp = r_x0;
    w_neg  = 1'b0;
    unique case (r_state)
      S_MAC1: begin w_coef = r_b1; w_samp = r_x1; end
      S_MAC2: begin w_coef = r_b2; w_samp = r_x2; end
      S_MAC3: begin
        w_coef = r_a1; w_samp = r_y1; w_neg = 1'b1;
      end
      S_MAC4: begin
        w_coef = r_a2; w_samp = r_y2; w_neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_prod     = w_coef * w_samp;
  assign w_prod_ext = {{3{w_prod[23]}}, w_prod};
  assign w_acc_nxt  = w_neg ? (r_acc - w_prod_ext)
                            : (r_acc + w_prod_ext);

`ifdef IIR_SAT_EN
  logic signed [16:0] w_shift;
  assign w_shift = w_acc_nxt[26:10];

  // Clamp the floored quotient into 12 bits
  always_comb begin
    w_scaled = w_shift[11:0];
    if (w_shift > 17'sd2047)
      w_scaled = 12'sd2047;
    else if (w_shift < -17'sd2048)
      w_scaled = -12'sd2048;
  end
`else
  assign w_scaled = w_acc_nxt[21:10];
`endif

  // Datapath: capture, accumulate, publish and shift history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      r_acc      <= '0;
      r_out_acc  <= '0;
      r_out_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_x0  <= bus.in_data;
          r_acc <= '0;
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3:
          r_acc <= w_acc_nxt;
        S_MAC4: begin
          r_acc      <= w_acc_nxt;
          r_out_acc  <= w_acc_nxt;
          r_out_data <= w_scaled;
          r_x2       <= r_x1;
          r_x1       <= r_x0;
          r_y2       <= r_y1;
          r_y1       <= w_scaled;
        end
        default: ;
      endcase
    end
  end

  assign w_cfg_ok = cfg_we && (r_state == S_IDLE)
                    && (cfg_addr <= 3'd4);

  // Coefficient bank, writable only between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0      <= 12'sd1006;
      r_b1      <= -12'sd1911;
      r_b2      <= 12'sd1006;
      r_a1      <= -12'sd1898;
      r_a2      <= 12'sd882;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) begin
        unique case (cfg_addr)
          3'd0:    r_b0 <= cfg_data;
          3'd1:    r_b1 <= cfg_data;
          3'd2:    r_b2 <= cfg_data;
          3'd3:    r_a1 <= cfg_data;
          default: r_a2 <= cfg_data;
        endcase
      end
    end
  end

endmodule
